signed_divider: RTL and testbench
=================================

# signed_divider

Sequential 8-bit signed two's-complement divider, the inverse datapath to the lab's shift-add multiplier. It performs restoring division, one quotient bit per clock, and uses the same board-level control model. The divisor is loaded from the switches; a later Execute divides the current switch value by it. Quotient and remainder are registered for the hex-display drivers.

## Interface
Parameters:
- WIDTH, 8, operand/result width (all rules below stated for 8)

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-high; clears all state
- LoadDivisor  in  1  active-high; in IDLE, captures SW into the divisor register at the clock edge
- Execute  in  1  active-high, level; start is taken on IDLE with Execute=1 and Armed=1
- SW  in  8  dividend at start; divisor source for LoadDivisor
- Quotient  out  8  signed quotient, truncated toward zero
- Remainder  out  8  signed remainder, sign of dividend
- Divisor  out  8  current divisor register contents
- Busy  out  1  high in ITER and FIX
- Done  out  1  high in DONE
- DivByZero  out  1  sticky per operation: last op had divisor 0
- Overflow  out  1  sticky per operation: last op was -128 / -1

## Operation
- States: IDLE, ITER, FIX, DONE (enum in package).
- Reset: state IDLE; Quotient, Remainder, Divisor = 0; Busy, Done, DivByZero, Overflow = 0; Armed = 1.
- IDLE:
  - LoadDivisor=1 → Divisor <= SW.
  - Execute=1 and Armed=1 → start. On the same edge:
    - Armed <= 0; clear DivByZero and Overflow.
    - Latch sign flags sQ = SW[7]^Divisor[7] and sR = SW[7].
    - Load working regs: quotient shift reg <= |SW|; partial remainder P (9 bits) <= 0; divisor magnitude D <= |Divisor|; cnt <= 0.
    - Magnitudes are 8-bit unsigned, so |-128| = 8'h80.
  - If LoadDivisor and a start coincide, the start uses the old Divisor; the load still occurs.
- Divisor==0 at start: state → DONE directly; DivByZero <= 1; Quotient <= 8'hFF; Remainder <= SW.
- ITER, each cycle:
  - {P,Q} shifted left 1.
  - T = P - D (9-bit). If T ≥ 0: P <= T, Q[0] <= 1; else Q[0] <= 0.
  - cnt++. After the 8th step (cnt==7) → FIX.
- FIX:
  - Quotient <= sQ ? -Q : Q.
  - Remainder <= sR ? -P[7:0] : P[7:0].
  - Overflow <= (dividend==8'h80 && Divisor==8'hFF); Quotient wraps to 8'h80.
  - → DONE.
- DONE: results held. When Execute=0: Armed <= 1, → IDLE. One operation per Execute assertion.
- Quotient/Remainder change only in FIX or on the divide-by-zero start; otherwise hold.
- LoadDivisor outside IDLE is ignored.

## Timing
- Edge E0 samples the start. ITER occupies edges E1–E8; FIX is E9.
- Done is high from E9 onward, and Quotient/Remainder are valid in the same cycle Done rises.
- Busy is high E0+ through E9.
- Divide-by-zero: Done is high after E0; Busy never rises.
- Reset mid-ITER/FIX: the next edge forces the full reset state; partial results are discarded and Divisor is cleared.
- Execute held high through IDLE after completion does not restart the divider (Armed=0).

## Structure
- Package divider_pkg: WIDTH localparam, state enum type, and the constants DIV0_QUOTIENT=8'hFF and MIN_NEG=8'h80.
- One sub-module, div_step: combinational single restoring step. Inputs P, Q, D; outputs next P, next Q.
- The top holds the FSM, counter, sign fix and registers.
- Hex decoding stays in the existing hex-driver instances at board level.

## Test plan
- Load divisor 8'h07. Execute with SW=8'hC5 (-59) → after 9 cycles Done=1, Quotient=8'hF8 (-8), Remainder=8'hFD (-3).
- Divisor 8'hF9 (-7), SW=8'h3B (59) → Quotient=8'hF8, Remainder=8'h03. Then SW=8'hC5 → Quotient=8'h08, Remainder=8'hFD.
- Divisor 0, SW=8'h07 → DivByZero=1, Quotient=8'hFF, Remainder=8'h07, Done one cycle after start, Busy=0 throughout.
- Divisor 8'hFF, SW=8'h80 → Overflow=1, Quotient=8'h80, Remainder=0.
- Execute held high 40 cycles → exactly one operation. Release and reassert → a second operation with identical results.
- Reset pulsed at ITER cycle 4 → next cycle all outputs 0, state IDLE. Also: LoadDivisor pulsed while Busy → Divisor unchanged.

Source files
------------

// File: rtl/signed_divider_pkg.sv
// Shared types and constants for the sequential signed divider.
package divider_pkg;

  localparam int WIDTH = 8;

  // Counter wide enough to index every quotient bit.
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

  // Quotient reported when the divisor is zero.
  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 8'hFF;

  // Most negative operand; its magnitude needs the full unsigned width.
  localparam logic [WIDTH-1:0] MIN_NEG = 8'h80;

  // Unsigned magnitude of a two's-complement value; MIN_NEG maps to itself,
  // which is exactly its magnitude when read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value);
    return value[WIDTH-1] ? -value : value;
  endfunction

endpackage

// File: rtl/signed_divider_if.sv
// Board-side control and result bus of the signed divider.
interface signed_divider_if;
  import divider_pkg::*;

  logic             load_divisor;
  logic             execute;
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;

  // Board controls and switches drive the divider; results flow back.
  modport master (
    output load_divisor, execute, sw,
    input  quotient, remainder, divisor, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  load_divisor, execute, sw,
    output quotient, remainder, divisor, busy, done, div_by_zero, overflow
  );

endinterface

// File: rtl/signed_divider_div_step.sv
// One restoring-division step on unsigned magnitudes.
module div_step
  import divider_pkg::*;
(
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Shift {P,Q} left, try subtracting D, keep the difference if it stays non-negative.
  always_comb begin
    shifted = {p, q[WIDTH-1]};
    trial   = shifted - {2'b00, d};
    if (!trial[WIDTH+1]) begin
      p_next = trial[WIDTH:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      p_next = shifted[WIDTH:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/signed_divider.sv
// Sequential 8-bit signed divider: one quotient bit per clock, results
// registered for the display drivers.
module signed_divider
  import divider_pkg::*;
(
  input logic              clk,
  input logic              reset,
  signed_divider_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_next;

  logic             start;
  logic             armed;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;
  logic             ovf_q;
  logic             ovf_pending;
  logic             sign_q;
  logic             sign_r;
  logic [WIDTH:0]   p_work;
  logic [WIDTH-1:0] q_work;
  logic [WIDTH-1:0] d_mag;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   p_step;
  logic [WIDTH-1:0] q_step;

  div_step u_step (
    .p      (p_work),
    .q      (q_work),
    .d      (d_mag),
    .p_next (p_step),
    .q_next (q_step)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a zero divisor skips straight to DONE.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        start = bus.execute && armed;
        if (start) state_next = (divisor_q == '0) ? DONE : ITER;
      end
      ITER: if (cnt == LAST_STEP) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (!bus.execute) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration registers, sign fix and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed       <= 1'b1;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      ovf_pending <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      p_work      <= '0;
      q_work      <= '0;
      d_mag       <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load_divisor) divisor_q <= bus.sw;
          if (start) begin
            armed       <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            sign_q      <= bus.sw[WIDTH-1] ^ divisor_q[WIDTH-1];
            sign_r      <= bus.sw[WIDTH-1];
            q_work      <= magnitude(bus.sw);
            p_work      <= '0;
            d_mag       <= magnitude(divisor_q);
            cnt         <= '0;
            ovf_pending <= (bus.sw == MIN_NEG) && (divisor_q == {WIDTH{1'b1}});
            if (divisor_q == '0) begin
              dbz_q       <= 1'b1;
              quotient_q  <= DIV0_QUOTIENT;
              remainder_q <= bus.sw;
            end
          end
        end
        ITER: begin
          p_work <= p_step;
          q_work <= q_step;
          cnt    <= cnt + CNT_W'(1);
        end
        FIX: begin
          quotient_q  <= sign_q ? -q_work : q_work;
          remainder_q <= sign_r ? -p_work[WIDTH-1:0] : p_work[WIDTH-1:0];
          ovf_q       <= ovf_pending;
        end
        DONE: begin
          if (!bus.execute) armed <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.divisor     = divisor_q;
  assign bus.busy        = (state == ITER) || (state == FIX);
  assign bus.done        = (state == DONE);
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_signed_divider.sv
// Directed self-checking bench for the signed divider.
module tb_signed_divider;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   busy_cycles;
  int   busy_rises;
  logic busy_prev;

  signed_divider_if bus ();

  signed_divider dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 50 MHz board clock.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_value(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic load_divisor_value(input logic [7:0] value);
    bus.sw           = value;
    bus.load_divisor = 1'b1;
    @(negedge clk);
    bus.load_divisor = 1'b0;
    check_value("divisor_load", bus.divisor, value);
  endtask

  // Full operation: Done must rise exactly nine edges after the start edge.
  task automatic run_division(input string tag, input logic [7:0] dividend,
                              input logic [7:0] exp_q, input logic [7:0] exp_r,
                              input logic exp_ovf);
    bus.sw      = dividend;
    bus.execute = 1'b1;
    @(negedge clk);
    check_bit({tag, "_busy_start"}, bus.busy, 1'b1);
    repeat (8) @(negedge clk);
    check_bit({tag, "_done_early"}, bus.done, 1'b0);
    check_bit({tag, "_busy_fix"}, bus.busy, 1'b1);
    @(negedge clk);
    check_bit({tag, "_done"}, bus.done, 1'b1);
    check_bit({tag, "_busy_end"}, bus.busy, 1'b0);
    check_value({tag, "_quotient"}, bus.quotient, exp_q);
    check_value({tag, "_remainder"}, bus.remainder, exp_r);
    check_bit({tag, "_ovf"}, bus.overflow, exp_ovf);
    check_bit({tag, "_dbz"}, bus.div_by_zero, 1'b0);
    bus.execute = 1'b0;
    @(negedge clk);
    check_bit({tag, "_idle"}, bus.done, 1'b0);
  endtask

  initial begin
    errors           = 0;
    checks           = 0;
    reset            = 1'b1;
    bus.load_divisor = 1'b0;
    bus.execute      = 1'b0;
    bus.sw           = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_value("rst_quotient", bus.quotient, 8'h00);
    check_value("rst_remainder", bus.remainder, 8'h00);
    check_value("rst_divisor", bus.divisor, 8'h00);
    check_bit("rst_busy", bus.busy, 1'b0);
    check_bit("rst_done", bus.done, 1'b0);
    check_bit("rst_dbz", bus.div_by_zero, 1'b0);
    check_bit("rst_ovf", bus.overflow, 1'b0);

    // -59 / 7 = -8 rem -3
    load_divisor_value(8'h07);
    run_division("neg_by_pos", 8'hC5, 8'hF8, 8'hFD, 1'b0);

    // 59 / -7 = -8 rem 3, then -59 / -7 = 8 rem -3
    load_divisor_value(8'hF9);
    run_division("pos_by_neg", 8'h3B, 8'hF8, 8'h03, 1'b0);
    run_division("neg_by_neg", 8'hC5, 8'h08, 8'hFD, 1'b0);

    // Divide by zero finishes one edge after the start without going busy.
    load_divisor_value(8'h00);
    bus.sw      = 8'h07;
    bus.execute = 1'b1;
    @(negedge clk);
    check_bit("dbz_done", bus.done, 1'b1);
    check_bit("dbz_busy", bus.busy, 1'b0);
    check_bit("dbz_flag", bus.div_by_zero, 1'b1);
    check_value("dbz_quotient", bus.quotient, 8'hFF);
    check_value("dbz_remainder", bus.remainder, 8'h07);
    bus.execute = 1'b0;
    @(negedge clk);
    check_bit("dbz_idle", bus.done, 1'b0);

    // -128 / -1 overflows and wraps to -128.
    load_divisor_value(8'hFF);
    run_division("overflow", 8'h80, 8'h80, 8'h00, 1'b1);

    // Execute held for 40 cycles yields a single operation.
    load_divisor_value(8'h07);
    bus.sw      = 8'hC5;
    bus.execute = 1'b1;
    busy_cycles = 0;
    busy_rises  = 0;
    busy_prev   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cycles++;
      if (bus.busy && !busy_prev) busy_rises++;
      busy_prev = bus.busy;
    end
    check_value("hold_busy_cycles", 8'(busy_cycles), 8'd9);
    check_value("hold_starts", 8'(busy_rises), 8'd1);
    check_bit("hold_done", bus.done, 1'b1);
    check_value("hold_quotient", bus.quotient, 8'hF8);
    bus.execute = 1'b0;
    @(negedge clk);
    run_division("rearm", 8'hC5, 8'hF8, 8'hFD, 1'b0);

    // LoadDivisor ignored while busy, then reset mid-iteration.
    bus.sw      = 8'hC5;
    bus.execute = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.sw           = 8'h55;
    bus.load_divisor = 1'b1;
    @(negedge clk);
    bus.load_divisor = 1'b0;
    check_value("busy_load_ignored", bus.divisor, 8'h07);
    check_bit("busy_mid", bus.busy, 1'b1);
    @(negedge clk);
    reset       = 1'b1;
    bus.execute = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_value("midrst_quotient", bus.quotient, 8'h00);
    check_value("midrst_remainder", bus.remainder, 8'h00);
    check_value("midrst_divisor", bus.divisor, 8'h00);
    check_bit("midrst_busy", bus.busy, 1'b0);
    check_bit("midrst_done", bus.done, 1'b0);

    // Recovery after reset: 10 / 3 = 3 rem 1
    load_divisor_value(8'h03);
    run_division("after_reset", 8'h0A, 8'h03, 8'h01, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
